// File: rtl/wb_sdr_port_arbiter.sv
// wb_sdr_port_arbiter: shares one Wishbone master port (feeding the
// Wishbone-to-SDRAM bridge) between NP slave ports. A grant is held for the
// whole Wishbone cycle (cyc), so bursts are never interleaved. Round-robin or
// fixed-priority arbitration is selected by PRIO_MODE.
// Optional stall abort: define WB_SDR_ARB_TIMEOUT_EN to abort a granted cycle
// after TIMEOUT unacknowledged strobe cycles (s_err_o pulse).
module wb_sdr_port_arbiter #(
   parameter int NP        = 4,
   parameter int AW        = 26,
   parameter int DW        = 32,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [NP-1:0]        s_cyc_i,
   input  logic [NP-1:0]        s_stb_i,
   input  logic [NP-1:0]        s_we_i,
   input  logic [NP*AW-1:0]     s_addr_i,
   input  logic [NP*DW-1:0]     s_dat_i,
   input  logic [NP*DW/8-1:0]   s_sel_i,
   input  logic [NP*3-1:0]      s_cti_i,
   output logic [DW-1:0]        s_dat_o,
   output logic [NP-1:0]        s_ack_o,
   output logic [NP-1:0]        s_err_o,
   output logic                 m_cyc_o,
   output logic                 m_stb_o,
   output logic                 m_we_o,
   output logic [AW-1:0]        m_addr_o,
   output logic [DW-1:0]        m_dat_o,
   output logic [DW/8-1:0]      m_sel_o,
   output logic [2:0]           m_cti_o,
   input  logic [DW-1:0]        m_dat_i,
   input  logic                 m_ack_i,
   output logic [NP-1:0]        grant_o
);

   localparam int SW = DW / 8;
   localparam int IW = $clog2(NP);

   if (NP < 2 || NP > 8 || TIMEOUT < 1) begin : g_param_chk
      $error("wb_sdr_port_arbiter: NP must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t          state_q;
   logic [NP-1:0]   grant_q;
   logic [IW-1:0]   gidx_q;
   logic [IW-1:0]   last_q;
   logic [NP-1:0]   req;
   logic [IW-1:0]   win;
   logic            found;
   logic            in_grant;
   logic            hit;

   assign in_grant = (state_q == GRANT);

`ifdef WB_SDR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]   cnt_q;
   logic [NP-1:0]   blk_q;

   // stall abort fires on the TIMEOUT-th unacknowledged strobe cycle
   assign hit     = in_grant & s_cyc_i[gidx_q] & s_stb_i[gidx_q] & ~m_ack_i &
                    (cnt_q == CW'(TIMEOUT - 1));
   assign s_err_o = grant_q & {NP{hit}};
   // an aborted port stays masked until it drops cyc
   assign req     = s_cyc_i & s_stb_i & ~blk_q;

   // stall counter: cleared outside GRANT and on every ack
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_q <= '0;
         blk_q <= '0;
      end else begin
         if (!in_grant || m_ack_i)   cnt_q <= '0;
         else if (s_stb_i[gidx_q])   cnt_q <= cnt_q + 1'b1;
         blk_q <= (blk_q | (grant_q & {NP{hit}})) & s_cyc_i;
      end
   end
`else
   assign hit     = 1'b0;
   assign s_err_o = '0;
   assign req     = s_cyc_i & s_stb_i;
`endif

   // winner search: lowest index, or starting just after the last winner
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NP; i++) begin : g_srch
         int j;
         j = (PRIO_MODE != 0) ? i : (int'(last_q) + 1 + i) % NP;
         if (!found && req[j]) begin
            win   = IW'(j);
            found = 1'b1;
         end
      end
   end

   // arbitration FSM: grant held for the whole cycle, one dead cycle after
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(NP - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q <= GRANT;
                  grant_q <= NP'(1) << win;
                  gidx_q  <= win;
                  last_q  <= win;
               end
            end
            GRANT: begin
               if (hit || !s_cyc_i[gidx_q]) begin
                  state_q <= RELEASE;
                  grant_q <= '0;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // master side follows the granted port; everything is 0 when not granted
   assign m_cyc_o  = in_grant & s_cyc_i[gidx_q] & ~hit;
   assign m_stb_o  = in_grant & s_stb_i[gidx_q] & ~hit;
   assign m_we_o   = in_grant & s_we_i[gidx_q];
   assign m_addr_o = in_grant ? s_addr_i[gidx_q*AW +: AW] : '0;
   assign m_dat_o  = in_grant ? s_dat_i[gidx_q*DW +: DW]  : '0;
   assign m_sel_o  = in_grant ? s_sel_i[gidx_q*SW +: SW]  : '0;
   assign m_cti_o  = in_grant ? s_cti_i[gidx_q*3 +: 3]    : '0;

   // return path: ack only to the owner, read data shared
   assign s_ack_o  = grant_q & {NP{m_ack_i & in_grant}};
   assign s_dat_o  = in_grant ? m_dat_i : '0;
   assign grant_o  = grant_q;

endmodule
